ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. Sends command bytes to the mouse, e.g. 0xFF reset, 0xF4 enable data reporting, 0xF3 set sample rate.
- Sits beside the PS/2 receiver that feeds the mouse packet decoder.
- Drives the open-drain PS/2 clock and data lines through output-enable signals.
- Top level gates the receiver's scan_code_ready with tx_busy, so device-generated clocks during a transmission are not decoded as scan codes.

---
 rtl/ps2_host_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Optional PS2_TX_RETRY_EN: up to three attempts per byte before tx_error.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10800,
  parameter int unsigned TIMEOUT_CYCLES = 2160000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned InhW  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRequest,
    StShift,
    StAck,
    StWaitIdle,
    StRetry
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      frame_q, frame_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]      edge_cnt_q, edge_cnt_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]      attempt_q, attempt_d;
`endif

  logic [SyncN-1:0] clk_sync_q, data_sync_q;
  logic             clk_prev_q;
  logic             clk_s, data_s, fall;
  logic             tmo_active, fail;

  assign clk_s  = clk_sync_q[SyncN-1];
  assign data_s = data_sync_q[SyncN-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Idle lines float high, so the synchronisers reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SyncN-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SyncN-2:0], ps2_data_in};
      clk_prev_q  <= clk_s;
    end
  end

  assign tmo_active = (state_q == StRequest) || (state_q == StShift) ||
                      (state_q == StAck) || (state_q == StWaitIdle);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    edge_cnt_d = edge_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    attempt_d  = attempt_q;
`endif

    if (tmo_active && (tmo_cnt_q != TmoLast)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        tmo_cnt_d = '0;
        // A request on the done/error cycle is dropped; busy is already low there.
        if (tx_start && !done_q && !err_q) begin
          frame_d    = {~^tx_data, tx_data};
          inh_cnt_d  = '0;
          edge_cnt_d = '0;
          clk_oe_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = StInhibit;
`ifdef PS2_TX_RETRY_EN
          attempt_d  = 2'd0;
`endif
        end
      end
      StInhibit: begin
        if (inh_cnt_q == InhLast) begin
          data_oe_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = StRequest;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      StRequest: begin
        clk_oe_d   = 1'b0;
        edge_cnt_d = '0;
        state_d    = StShift;
      end
      StShift: begin
        if (fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end else begin
            // Edges 1..9 present data bits LSB first, then parity.
            data_oe_d = ~frame_q[edge_cnt_q];
          end
        end
      end
      StAck: begin
        if (fall) begin
          if (!data_s) begin
            state_d = StWaitIdle;
          end else begin
            fail = 1'b1;
          end
        end
      end
      StWaitIdle: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StRetry: begin
        if (inh_cnt_q == InhLast) begin
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = StInhibit;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tmo_active && (tmo_cnt_q == TmoLast) && !done_d) begin
      fail = 1'b1;
    end

    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (attempt_q != 2'd2) begin
        attempt_d = attempt_q + 2'd1;
        inh_cnt_d = '0;
        state_d   = StRetry;
      end else begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
`else
      err_d   = 1'b1;
      busy_d  = 1'b0;
      state_d = StIdle;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      edge_cnt_q <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      attempt_q  <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_RETRY_EN
      attempt_q  <= attempt_d;
`endif
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model clocking at 1/40 clk.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk;
  logic       dev_data_low;

  int checks = 0;
  int errors = 0;

  // Open-drain wiring: either side can pull a line low.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Bus monitor, sampled on the falling clk edge.
  int cyc = 0;
  int inh_run = 0, last_inh = 0, inh_phases = 0;
  int req_run = 0, last_req_len = 0, req_cnt = 0, last_req_cyc = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, both_cnt = 0, long_cnt = 0;
  logic done_busy = 1'b0, err_busy = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  logic [1:0] err_oe = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps2_clk_oe && !ps2_data_oe) begin
      inh_run <= inh_run + 1;
    end else if (inh_run != 0) begin
      last_inh   <= inh_run;
      inh_phases <= inh_phases + 1;
      inh_run    <= 0;
    end
    if (ps2_clk_oe && ps2_data_oe) begin
      req_run <= req_run + 1;
      if (req_run == 0) begin
        last_req_cyc <= cyc;
        req_cnt      <= req_cnt + 1;
      end
    end else if (req_run != 0) begin
      last_req_len <= req_run;
      req_run      <= 0;
    end
    if (tx_done) begin
      done_cnt  <= done_cnt + 1;
      done_busy <= tx_busy;
    end
    if (tx_error) begin
      err_cnt  <= err_cnt + 1;
      err_cyc  <= cyc;
      err_oe   <= {ps2_clk_oe, ps2_data_oe};
      err_busy <= tx_busy;
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if ((tx_done && prev_done) || (tx_error && prev_err)) long_cnt <= long_cnt + 1;
    prev_done <= tx_done;
    prev_err  <= tx_error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wire frame a device should see: {stop, odd parity, data}.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock 11 pulses, sample on rising edges.
  task automatic dev_frame(input bit nack, output logic [9:0] frame, output logic start_bit,
                           output bit ok);
    int n = 0;
    ok        = 1'b0;
    frame     = '0;
    start_bit = 1'b1;
    while (!(ps2_clk_oe && ps2_data_oe) && n < 400) begin
      tick();
      n++;
    end
    if (n < 400) begin
      n = 0;
      while (ps2_clk_oe && n < 10) begin
        tick();
        n++;
      end
      repeat (HALF) tick();
      start_bit = ps2_data_in;
      for (int i = 0; i < 11; i++) begin
        dev_clk = 1'b0;
        repeat (HALF) tick();
        dev_clk = 1'b1;
        if (i < 10) frame[i] = ps2_data_in;
        if (i == 9) dev_data_low = !nack;
        if (i == 10) dev_data_low = 1'b0;
        if (i < 10) repeat (HALF) tick();
      end
      ok = 1'b1;
    end
  endtask

  task automatic good_tx(input logic [7:0] d, input bit poke);
    logic [9:0] fr;
    logic       sb;
    bit         ok;
    int         n = 0;
    int         br;
    br = req_cnt;
    start_tx(d);
    if (poke) begin
      repeat (5) tick();
      tx_data  = ~d;
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
    end
    dev_frame(1'b0, fr, sb, ok);
    chk("req_seen", 32'(ok), 32'd1);
    chk("start_bit", 32'(sb), 32'd0);
    chk("frame", 32'(fr), 32'(exp_frame(d)));
    while (!tx_done && !tx_error && n < 50) begin
      tick();
      n++;
    end
    chk("done_pulse", {tx_error, tx_done}, 32'b01);
    chk("busy_at_done", 32'(tx_busy), 32'd0);
    if (poke) begin
      chk("busy_start_ignored_req", 32'(req_cnt - br), 32'd1);
      chk("busy_start_ignored_inh", 32'(last_inh), 32'(INH));
    end
  endtask

  initial begin
    logic [9:0] fr;
    logic       sb;
    bit         ok;
    int         bd, be, bi, n;

    reset        = 1'b1;
    tx_data      = 8'h00;
    tx_start     = 1'b0;
    dev_clk      = 1'b1;
    dev_data_low = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // 0xF4 with inhibit/request timing and a start request on the done cycle.
    good_tx(8'hF4, 1'b0);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    chk("done_width", 32'(tx_done), 32'd0);
    chk("start_on_done_ignored", {tx_busy, ps2_clk_oe}, 32'd0);
    chk("inhibit_len", 32'(last_inh), 32'(INH));
    chk("request_len", 32'(last_req_len), 32'd1);
    repeat (5) tick();

    good_tx(8'h00, 1'b0);
    repeat (5) tick();
    good_tx(8'hFF, 1'b0);
    repeat (5) tick();
    for (int k = 0; k < 3; k++) begin
      good_tx(8'($urandom_range(0, 255)), (k == 1));
      repeat (5) tick();
    end

    // NACK on every attempt.
    bd = done_cnt;
    be = err_cnt;
    bi = inh_phases;
    start_tx(8'hF3);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(1'b1, fr, sb, ok);
      chk("nack_req_seen", 32'(ok), 32'd1);
      chk("nack_frame", 32'(fr), 32'(exp_frame(8'hF3)));
    end
    n = 0;
    while (err_cnt == be && n < 100) begin
      tick();
      n++;
    end
    chk("nack_error", 32'(err_cnt - be), 32'd1);
    chk("nack_no_done", 32'(done_cnt - bd), 32'd0);
    chk("nack_oe_released", 32'(err_oe), 32'd0);
    chk("nack_busy_low", 32'(err_busy), 32'd0);
    chk("nack_inhibit_phases", 32'(inh_phases - bi), 32'(ATTEMPTS));
    repeat (5) tick();

    // Device never clocks.
    bd = done_cnt;
    be = err_cnt;
    start_tx(8'hF4);
    n = 0;
    while (err_cnt == be && n < ATTEMPTS * 2100 + 100) begin
      tick();
      n++;
    end
    chk("timeout_error", 32'(err_cnt - be), 32'd1);
    chk("timeout_latency", 32'(err_cyc - last_req_cyc), 32'(TMO));
    chk("timeout_no_done", 32'(done_cnt - bd), 32'd0);
    chk("timeout_oe_released", 32'(err_oe), 32'd0);
    repeat (5) tick();

    // Reset at the fifth falling edge.
    bd = done_cnt;
    be = err_cnt;
    start_tx(8'hE0);
    n = 0;
    while (!(ps2_clk_oe && ps2_data_oe) && n < 100) begin
      tick();
      n++;
    end
    tick();
    repeat (HALF) tick();
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      repeat (HALF) tick();
    end
    dev_clk = 1'b0;
    repeat (4) tick();
    chk("edge5_data_bit4", {ps2_clk_oe, ps2_data_oe}, 32'b01);
    reset = 1'b1;
    tick();
    chk("midreset_oe", {ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("midreset_busy", {tx_busy, tx_done, tx_error}, 32'd0);
    reset   = 1'b0;
    dev_clk = 1'b1;
    repeat (100) tick();
    chk("midreset_no_completion", 32'((done_cnt - bd) + (err_cnt - be)), 32'd0);
    chk("done_error_overlap", 32'(both_cnt), 32'd0);
    chk("pulse_width", 32'(long_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
